biquad_cascade_sched: RTL and testbench

//  Time-multiplexes one 16x18 signed MAC across NUM_SECTIONS cascaded biquad sections.

---
 rtl/biquad_cascade_sched.sv | 225 ++++++++++++++++++++++
 tb/tb_biquad_cascade_sched.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/biquad_cascade_sched.sv
// Purpose: one shared 16x18 signed MAC walks NUM_SECTIONS cascaded biquads per audio sample.
// Latency: o_out_valid pulses 6*NUM_SECTIONS+2 cycles after the accepted lrclk_posedge.
// Backpressure: none; a strobe while busy is dropped and flagged on o_overrun, i_valid low flushes.
module biquad_cascade_sched #(
    parameter int NUM_SECTIONS = 4,
    parameter int FRAC_BITS    = 16
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic               lrclk_posedge,
    input  logic               i_valid,
    input  logic signed [15:0] x_in,
    input  logic               i_coef_we,
    input  logic [5:0]         i_coef_addr,
    input  logic signed [17:0] i_coef_data,
    input  logic               i_coef_commit,
    output logic signed [15:0] audio_out,
    output logic               o_out_valid,
    output logic               o_busy,
    output logic               o_overrun
);

    localparam int NCOEF = 5 * NUM_SECTIONS;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MAC,
        S_WB,
        S_OUT
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // coefficient banks: writes land in shadow, active only changes at frame start
    logic signed [17:0] r_shadow [NCOEF];
    logic signed [17:0] r_active [NCOEF];
    logic signed [17:0] w_shadow_nxt [NCOEF];
    logic               r_pending;

    // per-section delay line
    logic signed [15:0] r_x1 [NUM_SECTIONS];
    logic signed [15:0] r_x2 [NUM_SECTIONS];
    logic signed [15:0] r_y1 [NUM_SECTIONS];
    logic signed [15:0] r_y2 [NUM_SECTIONS];

    logic signed [15:0] r_cur;
    logic signed [36:0] r_acc;
    logic [2:0]         r_sec;
    logic [2:0]         r_tap;
    logic signed [15:0] r_audio;
    logic               r_out_valid;
    logic               r_overrun;

    logic               w_load_entry;
    logic               w_last_sec;
    logic signed [15:0] w_opnd;
    logic signed [17:0] w_coef;
    logic signed [33:0] w_prod;
    logic signed [36:0] w_shift;
    logic signed [15:0] w_y;

    assign w_load_entry = (r_state == S_IDLE) && lrclk_posedge && i_valid;
    assign w_last_sec   = (r_sec == 3'(NUM_SECTIONS - 1));
    assign w_prod       = 34'(w_opnd) * 34'(w_coef);
    assign w_shift      = r_acc >>> FRAC_BITS;

    assign audio_out   = r_audio;
    assign o_out_valid = r_out_valid;
    assign o_busy      = (r_state != S_IDLE);
    assign o_overrun   = r_overrun;

    // state register
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // next-state: section loop of 5 MAC cycles plus one writeback; i_valid low aborts
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (lrclk_posedge) w_state_nxt = S_LOAD;
            S_LOAD: w_state_nxt = S_MAC;
            S_MAC:  if (r_tap == 3'd4) w_state_nxt = S_WB;
            S_WB:   w_state_nxt = w_last_sec ? S_OUT : S_MAC;
            S_OUT:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (!i_valid) w_state_nxt = S_IDLE;
    end

    // operand and coefficient select for the current section/tap
    always_comb begin
        w_opnd = '0;
        w_coef = '0;
        for (int i = 0; i < NUM_SECTIONS; i++) begin
            if (r_sec == 3'(i)) begin
                case (r_tap)
                    3'd0:    w_opnd = r_cur;
                    3'd1:    w_opnd = r_x1[i];
                    3'd2:    w_opnd = r_x2[i];
                    3'd3:    w_opnd = r_y1[i];
                    default: w_opnd = r_y2[i];
                endcase
                for (int t = 0; t < 5; t++) begin
                    if (r_tap == 3'(t)) w_coef = r_active[i*5 + t];
                end
            end
        end
    end

    // rescale the accumulator and clamp to the 16-bit sample range
    always_comb begin
        w_y = w_shift[15:0];
        if (w_shift > 37'sd32767)       w_y = 16'sh7FFF;
        else if (w_shift < -37'sd32768) w_y = 16'sh8000;
    end

    // shadow bank with this cycle's write folded in, so a same-cycle copy includes it
    always_comb begin
        for (int k = 0; k < NCOEF; k++) begin
            w_shadow_nxt[k] = r_shadow[k];
            if (i_coef_we && (i_coef_addr == 6'(k))) w_shadow_nxt[k] = i_coef_data;
        end
    end

    // coefficient banks and sticky commit flag; copy happens only at frame start
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < NCOEF; k++) begin
                r_shadow[k] <= '0;
                r_active[k] <= '0;
            end
            r_pending <= 1'b0;
        end else begin
            for (int k = 0; k < NCOEF; k++) r_shadow[k] <= w_shadow_nxt[k];
            if (w_load_entry) begin
                if (r_pending) begin
                    for (int k = 0; k < NCOEF; k++) r_active[k] <= w_shadow_nxt[k];
                end
                // a commit arriving on the frame-start cycle is held for the next frame
                r_pending <= i_coef_commit;
            end else if (i_coef_commit) begin
                r_pending <= 1'b1;
            end
        end
    end

    // datapath: sample latch, MAC accumulation, section writeback and output register
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_SECTIONS; i++) begin
                r_x1[i] <= '0;
                r_x2[i] <= '0;
                r_y1[i] <= '0;
                r_y2[i] <= '0;
            end
            r_cur       <= '0;
            r_acc       <= '0;
            r_sec       <= '0;
            r_tap       <= '0;
            r_audio     <= '0;
            r_out_valid <= 1'b0;
        end else if (!i_valid) begin
            for (int i = 0; i < NUM_SECTIONS; i++) begin
                r_x1[i] <= '0;
                r_x2[i] <= '0;
                r_y1[i] <= '0;
                r_y2[i] <= '0;
            end
            r_cur       <= '0;
            r_acc       <= '0;
            r_sec       <= '0;
            r_tap       <= '0;
            r_audio     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // x_in is only guaranteed on the strobe cycle
                    if (lrclk_posedge) r_cur <= x_in;
                end
                S_LOAD: begin
                    r_sec <= '0;
                    r_tap <= '0;
                    r_acc <= '0;
                end
                S_MAC: begin
                    r_acc <= r_acc + 37'(w_prod);
                    r_tap <= (r_tap == 3'd4) ? 3'd0 : r_tap + 3'd1;
                end
                S_WB: begin
                    for (int i = 0; i < NUM_SECTIONS; i++) begin
                        if (r_sec == 3'(i)) begin
                            r_x2[i] <= r_x1[i];
                            r_x1[i] <= r_cur;
                            r_y2[i] <= r_y1[i];
                            r_y1[i] <= w_y;
                        end
                    end
                    r_cur <= w_y;
                    r_acc <= '0;
                    if (w_last_sec) begin
                        // output registered here so data and pulse appear together in OUT
                        r_audio     <= w_y;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_sec <= r_sec + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // flag strobes that arrive while a frame is still in flight
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) r_overrun <= 1'b0;
        else          r_overrun <= lrclk_posedge && (r_state != S_IDLE);
    end

endmodule

// File: tb/tb_biquad_cascade_sched.sv
// Bench for biquad_cascade_sched with two sections: directed frames feed a scoreboard
// of expected samples and output cycles; a negedge monitor pops and compares on o_out_valid.
module tb_biquad_cascade_sched;

    localparam int NS  = 2;
    localparam int LAT = 6 * NS + 2;

    logic               clk = 1'b0;
    logic               i_rst_n;
    logic               lrclk_posedge;
    logic               i_valid;
    logic signed [15:0] x_in;
    logic               i_coef_we;
    logic [5:0]         i_coef_addr;
    logic signed [17:0] i_coef_data;
    logic               i_coef_commit;
    logic signed [15:0] audio_out;
    logic               o_out_valid;
    logic               o_busy;
    logic               o_overrun;

    biquad_cascade_sched #(.NUM_SECTIONS(NS), .FRAC_BITS(16)) dut (
        .clk           (clk),
        .i_rst_n       (i_rst_n),
        .lrclk_posedge (lrclk_posedge),
        .i_valid       (i_valid),
        .x_in          (x_in),
        .i_coef_we     (i_coef_we),
        .i_coef_addr   (i_coef_addr),
        .i_coef_data   (i_coef_data),
        .i_coef_commit (i_coef_commit),
        .audio_out     (audio_out),
        .o_out_valid   (o_out_valid),
        .o_busy        (o_busy),
        .o_overrun     (o_overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic signed [15:0] val;
        int                 at;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wr(input int a, input int d, input bit commit);
        i_coef_we     = 1'b1;
        i_coef_addr   = 6'(a);
        i_coef_data   = 18'(d);
        i_coef_commit = commit;
        tick();
        i_coef_we     = 1'b0;
        i_coef_commit = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (o_busy && n < 100) begin
            tick();
            n++;
        end
        chk("busy_timeout", int'(o_busy), 0);
        tick();
    endtask

    // strobe one sample; optionally expect an output and inject an overrun strobe
    task automatic frame(input int x, input int expv, input bit push, input int ovr_at);
        exp_t e;
        lrclk_posedge = 1'b1;
        x_in          = 16'(x);
        if (push) begin
            e.val = 16'(expv);
            e.at  = cyc + LAT;
            sb.push_back(e);
        end
        tick();
        lrclk_posedge = 1'b0;
        if (ovr_at > 0) begin
            repeat (ovr_at - 1) tick();
            lrclk_posedge = 1'b1;
            x_in          = 16'sd5000;
            tick();
            lrclk_posedge = 1'b0;
            chk("overrun_pulse", int'(o_overrun), 1);
            tick();
            chk("overrun_clear", int'(o_overrun), 0);
        end
        wait_idle();
    endtask

    // scoreboard monitor
    initial begin : mon
        exp_t e;
        forever begin
            @(negedge clk);
            if (i_rst_n && o_out_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got audio_out %0d expected no pulse (cycle %0d)", audio_out, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("audio_out", int'(audio_out), int'(e.val));
                    chk("valid_cycle", cyc, e.at);
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        i_rst_n       = 1'b0;
        lrclk_posedge = 1'b0;
        i_valid       = 1'b1;
        x_in          = '0;
        i_coef_we     = 1'b0;
        i_coef_addr   = '0;
        i_coef_data   = '0;
        i_coef_commit = 1'b0;
        repeat (3) tick();
        chk("rst_audio_out", int'(audio_out), 0);
        chk("rst_out_valid", int'(o_out_valid), 0);
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_overrun", int'(o_overrun), 0);
        i_rst_n = 1'b1;
        tick();

        // passthrough, write and commit on the same cycle for section 1
        wr(0, 65536, 1'b0);
        wr(5, 65536, 1'b1);
        frame(1234, 1234, 1'b1, 0);
        frame(-1234, -1234, 1'b1, 0);
        frame(32767, 32767, 1'b1, 0);

        // recursion in section 0 from a flushed state
        wr(0, 32768, 1'b0);
        wr(3, 32768, 1'b1);
        i_valid = 1'b0;
        tick();
        i_valid = 1'b1;
        chk("flush_idle_audio", int'(audio_out), 0);
        frame(1000, 500, 1'b1, 0);
        frame(0, 250, 1'b1, 0);
        frame(0, 125, 1'b1, 0);
        frame(0, 62, 1'b1, 0);
        frame(0, 31, 1'b1, 0);

        // overrun at busy cycle 5 must not disturb the frame
        frame(0, 15, 1'b1, 5);

        // flush mid-frame: no pulse, output zeroed, delay state cleared
        lrclk_posedge = 1'b1;
        x_in          = 16'sd1000;
        tick();
        lrclk_posedge = 1'b0;
        repeat (4) tick();
        i_valid = 1'b0;
        tick();
        i_valid = 1'b1;
        chk("flush_audio_out", int'(audio_out), 0);
        chk("flush_busy", int'(o_busy), 0);
        chk("flush_out_valid", int'(o_out_valid), 0);
        tick();
        frame(0, 0, 1'b1, 0);
        frame(1000, 500, 1'b1, 0);

        // saturation both directions
        wr(0, 131071, 1'b0);
        wr(3, 0, 1'b1);
        frame(30000, 32767, 1'b1, 0);
        frame(-30000, -32768, 1'b1, 0);

        // commit during a busy frame applies only from the next frame
        wr(0, 65536, 1'b1);
        frame(1000, 1000, 1'b1, 0);
        begin
            exp_t e;
            lrclk_posedge = 1'b1;
            x_in          = 16'sd1000;
            e.val = 16'sd1000;
            e.at  = cyc + LAT;
            sb.push_back(e);
            tick();
            lrclk_posedge = 1'b0;
            tick();
            tick();
            wr(0, 32768, 1'b1);
            wait_idle();
        end
        frame(1000, 500, 1'b1, 0);
        i_coef_commit = 1'b1;
        tick();
        i_coef_commit = 1'b0;
        frame(1000, 500, 1'b1, 0);

        // asynchronous reset in the middle of section 0 MAC
        lrclk_posedge = 1'b1;
        x_in          = 16'sd1000;
        tick();
        lrclk_posedge = 1'b0;
        repeat (4) tick();
        i_rst_n = 1'b0;
        #1;
        chk("midrst_audio_out", int'(audio_out), 0);
        chk("midrst_busy", int'(o_busy), 0);
        chk("midrst_out_valid", int'(o_out_valid), 0);
        chk("midrst_overrun", int'(o_overrun), 0);
        tick();
        i_rst_n = 1'b1;
        tick();
        wr(0, 32768, 1'b0);
        wr(3, 32768, 1'b0);
        wr(5, 65536, 1'b1);
        frame(1000, 500, 1'b1, 0);
        frame(0, 250, 1'b1, 0);

        repeat (3) tick();
        chk("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
